omnivision_spi_rx: RTL and testbench

Receive-side deserializer for the two-lane Omnivision serial pixel link. It samples `sclk`/`sdat[1:0]` in the system clock domain, assembles bytes, and locks to the 8-byte frame header. It then re-creates a parallel 8-bit pixel stream with `fv`/`lv`/`dv` framing for the downstream imager pipeline, and it sits directly after the sensor serial interface.

---
 rtl/omnivision_spi_rx.sv | 238 +++++++++++++++++++++++
 tb/tb_omnivision_spi_rx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/omnivision_spi_rx.sv
`timescale 1ns/1ps
// Two-lane Omnivision serial link receiver: synchronizes sclk/sdat, assembles bytes,
// locks to the FF FF 00 header and re-creates a framed 8-bit pixel stream.
module omnivision_spi_rx #(
    parameter int unsigned IDLE_CYCLES = 16,
    parameter logic [7:0]  MODE_RAW8   = 8'h2A
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic        i_sclk,
    input  logic [1:0]  i_sdat,
    output logic [7:0]  o_data,
    output logic        o_dv,
    output logic        o_fv,
    output logic        o_lv,
    output logic [15:0] o_num_rows,
    output logic [15:0] o_num_cols,
    output logic        o_hdr_valid,
    output logic        o_frame_done,
    output logic        o_error
);
    localparam int unsigned IdleW = $clog2(IDLE_CYCLES + 1);

    typedef enum logic [2:0] {StHunt, StSync1, StSync2, StHdr, StData} state_e;

    logic             r_sclk_s1, r_sclk_s2, r_sclk_prev;
    logic [1:0]       r_sdat_s1, r_sdat_s2;
    logic [1:0]       r_pos;
    logic [IdleW-1:0] r_idle;
    logic [5:0]       r_shift;
    logic [7:0]       r_byte;
    logic             r_byte_stb;
    logic             w_edge, w_timeout;
    logic [1:0]       w_pos_eff;

    assign w_edge    = r_sclk_s2 & ~r_sclk_prev;
    assign w_timeout = (r_idle == IdleW'(IDLE_CYCLES));
    // A coincident edge wins over the timeout but lands at pair position 0.
    assign w_pos_eff = w_timeout ? 2'd0 : r_pos;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sclk_s1   <= 1'b0;
            r_sclk_s2   <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_sdat_s1   <= 2'd0;
            r_sdat_s2   <= 2'd0;
            r_pos       <= 2'd0;
            r_idle      <= '0;
            r_shift     <= 6'd0;
            r_byte      <= 8'd0;
            r_byte_stb  <= 1'b0;
        end else begin
            r_sclk_s1   <= i_sclk;
            r_sclk_s2   <= r_sclk_s1;
            r_sclk_prev <= r_sclk_s2;
            r_sdat_s1   <= i_sdat;
            r_sdat_s2   <= r_sdat_s1;
            r_byte_stb  <= 1'b0;
            if (!i_enable) begin
                r_pos  <= 2'd0;
                r_idle <= '0;
            end else if (w_edge) begin
                r_idle <= '0;
                r_pos  <= w_pos_eff + 2'd1;
                case (w_pos_eff)
                    2'd0:    r_shift[1:0] <= r_sdat_s2;
                    2'd1:    r_shift[3:2] <= r_sdat_s2;
                    2'd2:    r_shift[5:4] <= r_sdat_s2;
                    default: begin
                        r_byte     <= {r_sdat_s2, r_shift};
                        r_byte_stb <= 1'b1;
                    end
                endcase
            end else if (w_timeout) begin
                r_pos <= 2'd0;
            end else begin
                r_idle <= r_idle + IdleW'(1);
            end
        end
    end

    state_e      r_state, w_state_d;
    logic [2:0]  r_hdr_cnt, w_hdr_cnt_d;
    logic [7:0]  r_mode, w_mode_d;
    logic [15:0] r_rows_sh, w_rows_sh_d;
    logic [7:0]  r_cols_hi, w_cols_hi_d;
    logic [15:0] r_num_rows, w_num_rows_d, r_num_cols, w_num_cols_d;
    logic [15:0] r_row, w_row_d, r_col, w_col_d;
    logic [7:0]  r_data, w_data_d;
    logic        r_dv, w_dv_d, r_fv, w_fv_d, r_lv, w_lv_d;
    logic        r_hdr_valid, w_hdr_valid_d, r_frame_done, w_frame_done_d, r_error, w_error_d;
    logic        r_eol, w_eol_d, r_eof, w_eof_d;
    logic [15:0] w_cols_new;
    logic        w_hdr_bad;

    assign w_cols_new = {r_cols_hi, r_byte};
    assign w_hdr_bad  = (r_mode != MODE_RAW8) || (r_rows_sh == 16'd0) || (w_cols_new == 16'd0);

    always_comb begin
        w_state_d      = r_state;
        w_hdr_cnt_d    = r_hdr_cnt;
        w_mode_d       = r_mode;
        w_rows_sh_d    = r_rows_sh;
        w_cols_hi_d    = r_cols_hi;
        w_num_rows_d   = r_num_rows;
        w_num_cols_d   = r_num_cols;
        w_row_d        = r_row;
        w_col_d        = r_col;
        w_data_d       = r_data;
        w_dv_d         = 1'b0;
        w_fv_d         = r_fv;
        w_lv_d         = r_lv;
        w_hdr_valid_d  = 1'b0;
        w_frame_done_d = 1'b0;
        w_error_d      = 1'b0;
        w_eol_d        = 1'b0;
        w_eof_d        = 1'b0;
        // lv (and fv at frame end) drop one cycle after the row's last dv.
        if (r_eol) begin
            w_lv_d = 1'b0;
            if (r_eof) w_fv_d = 1'b0;
        end
        if (!i_enable) begin
            w_state_d = StHunt;
            w_fv_d    = 1'b0;
            w_lv_d    = 1'b0;
        end else if (r_byte_stb) begin
            case (r_state)
                StHunt: if (r_byte == 8'hFF) w_state_d = StSync1;
                StSync1: w_state_d = (r_byte == 8'hFF) ? StSync2 : StHunt;
                StSync2: begin
                    if (r_byte == 8'h00) begin
                        w_state_d   = StHdr;
                        w_hdr_cnt_d = 3'd0;
                    end else if (r_byte != 8'hFF) begin
                        w_state_d = StHunt;
                    end
                end
                StHdr: begin
                    w_hdr_cnt_d = r_hdr_cnt + 3'd1;
                    case (r_hdr_cnt)
                        3'd0: w_mode_d          = r_byte;
                        3'd1: w_rows_sh_d[15:8] = r_byte;
                        3'd2: w_rows_sh_d[7:0]  = r_byte;
                        3'd3: w_cols_hi_d       = r_byte;
                        default: begin
                            if (w_hdr_bad) begin
                                w_error_d = 1'b1;
                                w_state_d = StHunt;
                            end else begin
                                w_num_rows_d  = r_rows_sh;
                                w_num_cols_d  = w_cols_new;
                                w_hdr_valid_d = 1'b1;
                                w_fv_d        = 1'b1;
                                w_row_d       = 16'd0;
                                w_col_d       = 16'd0;
                                w_state_d     = StData;
                            end
                        end
                    endcase
                end
                StData: begin
                    w_data_d = r_byte;
                    w_dv_d   = 1'b1;
                    w_lv_d   = 1'b1;
                    if (r_col == r_num_cols - 16'd1) begin
                        w_col_d = 16'd0;
                        w_eol_d = 1'b1;
                        if (r_row == r_num_rows - 16'd1) begin
                            w_frame_done_d = 1'b1;
                            w_eof_d        = 1'b1;
                            w_state_d      = StHunt;
                        end else begin
                            w_row_d = r_row + 16'd1;
                        end
                    end else begin
                        w_col_d = r_col + 16'd1;
                    end
                end
                default: w_state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= StHunt;
            r_hdr_cnt    <= 3'd0;
            r_mode       <= 8'd0;
            r_rows_sh    <= 16'd0;
            r_cols_hi    <= 8'd0;
            r_num_rows   <= 16'd0;
            r_num_cols   <= 16'd0;
            r_row        <= 16'd0;
            r_col        <= 16'd0;
            r_data       <= 8'd0;
            r_dv         <= 1'b0;
            r_fv         <= 1'b0;
            r_lv         <= 1'b0;
            r_hdr_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_error      <= 1'b0;
            r_eol        <= 1'b0;
            r_eof        <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_hdr_cnt    <= w_hdr_cnt_d;
            r_mode       <= w_mode_d;
            r_rows_sh    <= w_rows_sh_d;
            r_cols_hi    <= w_cols_hi_d;
            r_num_rows   <= w_num_rows_d;
            r_num_cols   <= w_num_cols_d;
            r_row        <= w_row_d;
            r_col        <= w_col_d;
            r_data       <= w_data_d;
            r_dv         <= w_dv_d;
            r_fv         <= w_fv_d;
            r_lv         <= w_lv_d;
            r_hdr_valid  <= w_hdr_valid_d;
            r_frame_done <= w_frame_done_d;
            r_error      <= w_error_d;
            r_eol        <= w_eol_d;
            r_eof        <= w_eof_d;
        end
    end

    assign o_data       = r_data;
    assign o_dv         = r_dv;
    assign o_fv         = r_fv;
    assign o_lv         = r_lv;
    assign o_num_rows   = r_num_rows;
    assign o_num_cols   = r_num_cols;
    assign o_hdr_valid  = r_hdr_valid;
    assign o_frame_done = r_frame_done;
    assign o_error      = r_error;
endmodule

// File: tb/tb_omnivision_spi_rx.sv
`timescale 1ns/1ps
// Scoreboard bench for omnivision_spi_rx: stimulus pushes expected events,
// a negedge monitor pops and compares whenever dv, hdr_valid or error fires.
module tb_omnivision_spi_rx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        sclk = 1'b0;
    logic [1:0]  sdat = 2'd0;
    logic [7:0]  o_data;
    logic        o_dv, o_fv, o_lv, o_hdr_valid, o_frame_done, o_error;
    logic [15:0] o_num_rows, o_num_cols;

    always #5 clk = ~clk;

    omnivision_spi_rx dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_enable     (en),
        .i_sclk       (sclk),
        .i_sdat       (sdat),
        .o_data       (o_data),
        .o_dv         (o_dv),
        .o_fv         (o_fv),
        .o_lv         (o_lv),
        .o_num_rows   (o_num_rows),
        .o_num_cols   (o_num_cols),
        .o_hdr_valid  (o_hdr_valid),
        .o_frame_done (o_frame_done),
        .o_error      (o_error)
    );

    localparam int KDv = 0, KHdr = 1, KErr = 2;
    typedef struct {
        int          kind;
        logic [7:0]  data;
        logic        eol;
        logic        eof;
        logic [15:0] rows;
        logic [15:0] cols;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_hdr  = 0;
    logic pend = 1'b0, pend_lv = 1'b0, pend_fv = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_dv(input logic [7:0] d, input logic eol, input logic eof);
        exp_t e;
        e.kind = KDv; e.data = d; e.eol = eol; e.eof = eof; e.rows = 16'd0; e.cols = 16'd0;
        q.push_back(e);
    endtask

    task automatic push_hdr(input logic [15:0] r, input logic [15:0] c);
        exp_t e;
        e.kind = KHdr; e.data = 8'd0; e.eol = 1'b0; e.eof = 1'b0; e.rows = r; e.cols = c;
        q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.kind = KErr; e.data = 8'd0; e.eol = 1'b0; e.eof = 1'b0; e.rows = 16'd0; e.cols = 16'd0;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_pair(input logic [1:0] p);
        sdat = p;
        idle(4);
        sclk = 1'b1;
        idle(4);
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 4; i++) send_pair(b[2*i +: 2]);
    endtask

    task automatic send_hdr(input logic [7:0] mode, input logic [15:0] r, input logic [15:0] c);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'h00);
        send_byte(mode);
        send_byte(r[15:8]);
        send_byte(r[7:0]);
        send_byte(c[15:8]);
        send_byte(c[7:0]);
    endtask

    // Monitor: outputs settle after posedge, sampled on negedge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (pend) begin
            chk("lv_after_dv", o_lv, pend_lv);
            chk("fv_after_dv", o_fv, pend_fv);
            pend = 1'b0;
        end
        if (o_dv || o_hdr_valid || o_error) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: dv=%0b hdr_valid=%0b error=%0b data=%0h, none expected (t=%0t)",
                         o_dv, o_hdr_valid, o_error, o_data, $time);
            end else begin
                e = q.pop_front();
                if (e.kind == KDv) begin
                    chk("dv_event", o_dv, 1);
                    chk("data", o_data, e.data);
                    chk("frame_done", o_frame_done, e.eof);
                    chk("lv_with_dv", o_lv, 1);
                    chk("fv_with_dv", o_fv, 1);
                    pend    = 1'b1;
                    pend_lv = !e.eol;
                    pend_fv = !e.eof;
                end else if (e.kind == KHdr) begin
                    n_hdr++;
                    chk("hdr_valid_event", o_hdr_valid, 1);
                    chk("num_rows", o_num_rows, e.rows);
                    chk("num_cols", o_num_cols, e.cols);
                    chk("fv_with_hdr", o_fv, 1);
                end else begin
                    chk("error_event", o_error, 1);
                    chk("fv_with_error", o_fv, 0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hdr_before;
        idle(3);
        chk("rst_data", o_data, 0);
        chk("rst_dv", o_dv, 0);
        chk("rst_fv", o_fv, 0);
        chk("rst_lv", o_lv, 0);
        chk("rst_num_rows", o_num_rows, 0);
        chk("rst_num_cols", o_num_cols, 0);
        chk("rst_hdr_valid", o_hdr_valid, 0);
        chk("rst_frame_done", o_frame_done, 0);
        chk("rst_error", o_error, 0);
        rst = 1'b0;
        en  = 1'b1;
        idle(4);

        // Nominal 2x3 frame.
        push_hdr(16'd2, 16'd3);
        push_dv(8'h10, 0, 0); push_dv(8'h11, 0, 0); push_dv(8'h12, 1, 0);
        push_dv(8'h13, 0, 0); push_dv(8'h14, 0, 0); push_dv(8'h15, 1, 1);
        send_hdr(8'h2A, 16'd2, 16'd3);
        for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i));
        idle(24);
        chk("nominal_fv_low", o_fv, 0);

        // Repeated sync bytes, 1x1 frame.
        push_hdr(16'd1, 16'd1);
        push_dv(8'hA5, 1, 1);
        send_byte(8'hFF); send_byte(8'hFF);
        send_hdr(8'h2A, 16'd1, 16'd1);
        send_byte(8'hA5);
        idle(24);

        // Bad mode, then zero rows; dimensions must survive.
        push_err();
        send_hdr(8'h2B, 16'd2, 16'd3);
        idle(24);
        push_err();
        send_hdr(8'h2A, 16'd0, 16'd3);
        idle(24);
        chk("rows_kept", o_num_rows, 1);
        chk("cols_kept", o_num_cols, 1);
        chk("bad_hdr_fv", o_fv, 0);

        // Valid header after the bad ones, 1x2 frame.
        push_hdr(16'd1, 16'd2);
        push_dv(8'h33, 0, 0); push_dv(8'h44, 1, 1);
        send_hdr(8'h2A, 16'd1, 16'd2);
        send_byte(8'h33); send_byte(8'h44);
        idle(24);

        // Stray pair followed by idle gap realigns.
        send_pair(2'd0);
        idle(24);
        push_hdr(16'd1, 16'd1);
        push_dv(8'h5A, 1, 1);
        send_hdr(8'h2A, 16'd1, 16'd1);
        send_byte(8'h5A);
        idle(24);

        // Stray pair without a gap: bytes are shifted and never lock.
        hdr_before = n_hdr;
        send_pair(2'd0);
        send_hdr(8'h2A, 16'd1, 16'd1);
        send_byte(8'h5A);
        idle(24);
        chk("misaligned_no_hdr", n_hdr, hdr_before);
        chk("misaligned_fv", o_fv, 0);

        // Drop enable after the 2nd pixel of a 2x3 frame.
        push_hdr(16'd2, 16'd3);
        push_dv(8'h60, 0, 0); push_dv(8'h61, 0, 0);
        send_hdr(8'h2A, 16'd2, 16'd3);
        send_byte(8'h60); send_byte(8'h61);
        idle(2);
        en = 1'b0;
        idle(1);
        chk("abort_fv", o_fv, 0);
        chk("abort_lv", o_lv, 0);
        send_byte(8'h62); send_byte(8'h63);
        idle(24);
        en = 1'b1;
        idle(4);

        // Reset mid-row clears outputs at once; hunting restarts afterwards.
        push_hdr(16'd2, 16'd3);
        push_dv(8'h70, 0, 0);
        send_hdr(8'h2A, 16'd2, 16'd3);
        send_byte(8'h70);
        idle(2);
        chk("mid_row_lv", o_lv, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_fv", o_fv, 0);
        chk("rst_mid_lv", o_lv, 0);
        chk("rst_mid_data", o_data, 0);
        chk("rst_mid_num_rows", o_num_rows, 0);
        chk("rst_mid_num_cols", o_num_cols, 0);
        idle(3);
        rst = 1'b0;
        idle(4);
        push_hdr(16'd1, 16'd1);
        push_dv(8'hC3, 1, 1);
        send_hdr(8'h2A, 16'd1, 16'd1);
        send_byte(8'hC3);
        idle(24);

        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
